// File: rtl/cat_pkg.sv
// Shared definitions for the packed-nibble link (packer and unpacker).
//
// A beat on the link is 4 bits:
//   [3]   frame start
//   [2:1] two bits of x, most significant pair first
//   [0]   one bit of y, most significant bit first
package cat_pkg;

  localparam int CAT_SOF_BIT = 3;
  localparam int CAT_X_MSB   = 2;
  localparam int CAT_X_LSB   = 1;
  localparam int CAT_Y_BIT   = 0;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  // Beats per frame: each beat carries two x bits.
  function automatic int beats_per_frame(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/cat_unpacker.sv
// cat_unpacker: reassembles x/y words from a stream of 4-bit packed beats.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   cat_valid  beat present
//   cat_ready  beat accepted when cat_valid & cat_ready (state-decoded, registered)
//   cat        beat: [3]=frame start, [2:1]=two x bits, [0]=one y bit
//   x          reassembled x word (WIDTH bits)
//   y          reassembled y bits, zero-extended above the N payload bits
//   out_valid  word available
//   out_ready  consumer accepts when out_valid & out_ready
//   err        one-cycle framing-error pulse, one cycle after the offending beat
//
// WIDTH must be even and >= 4, so a frame always has at least two beats.
module cat_unpacker
  import cat_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cat_valid,
  output logic             cat_ready,
  input  logic [3:0]       cat,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);

  localparam int N  = beats_per_frame(WIDTH);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  y_q;

  logic       beat_take;
  logic       beat_sof;
  logic [1:0] beat_x;
  logic       beat_y;

  assign beat_take = cat_valid & cat_ready;
  assign beat_sof  = cat[CAT_SOF_BIT];
  assign beat_x    = cat[CAT_X_MSB:CAT_X_LSB];
  assign beat_y    = cat[CAT_Y_BIT];

  assign y = {{(WIDTH - N){1'b0}}, y_q};

  // NOTE: every register here is written with <= so that all state updates
  // see the pre-edge values, exactly like the flops they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      x         <= '0;
      y_q       <= '0;
      out_valid <= 1'b0;
      cat_ready <= 1'b1;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (beat_take) begin
            if (beat_sof) begin
              // Older bits get shifted out over the frame, so no clear needed.
              x     <= {x[WIDTH-3:0], beat_x};
              y_q   <= {y_q[N-2:0], beat_y};
              cnt   <= CW'(1);
              state <= COLLECT;
            end else begin
              // Beat without a frame in progress: drop it and flag it.
              err <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (beat_take) begin
            x   <= {x[WIDTH-3:0], beat_x};
            y_q <= {y_q[N-2:0], beat_y};
            if (beat_sof) begin
              // Premature start: abandon the partial frame, this beat is beat 0.
              err <= 1'b1;
              cnt <= CW'(1);
            end else if (cnt == LAST) begin
              cnt       <= '0;
              state     <= HOLD;
              out_valid <= 1'b1;
              cat_ready <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end

        HOLD: begin
          // x/y are left untouched after the handshake.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            cat_ready <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          out_valid <= 1'b0;
          cat_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cat_unpacker.sv
// Self-checking bench for cat_unpacker (WIDTH=8): directed frames plus a
// randomized stream checked against a frame-level reference model.
module tb_cat_unpacker;

  localparam int W = 8;
  localparam int N = W / 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         cat_valid;
  logic         cat_ready;
  logic [3:0]   cat;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: beats of the frame in progress, and the word on offer.
  logic [3:0]   beats[$];
  bit           holding;
  bit           exp_err;
  logic [W-1:0] exp_x;
  logic [W-1:0] exp_y;
  int           words_out = 0;

  cat_unpacker #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cat_valid (cat_valid),
    .cat_ready (cat_ready),
    .cat       (cat),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    beats.delete();
    holding = 1'b0;
    exp_err = 1'b0;
    exp_x   = '0;
    exp_y   = '0;
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(input logic v, input logic [3:0] c, input logic ordy);
    bit accept;
    accept  = v && !holding;
    exp_err = 1'b0;
    if (holding && ordy) begin
      holding = 1'b0;
      words_out++;
    end else if (accept) begin
      if (c[3]) begin
        if (beats.size() != 0) exp_err = 1'b1;
        beats.delete();
        beats.push_back(c);
      end else if (beats.size() == 0) begin
        exp_err = 1'b1;
      end else begin
        beats.push_back(c);
      end
      if (beats.size() == N) begin
        // Beat k supplies x[W-1-2k : W-2-2k] and y[N-1-k].
        exp_x = '0;
        exp_y = '0;
        for (int k = 0; k < N; k++) begin
          exp_x = exp_x | (W'(beats[k][2:1]) << (W - 2 - 2 * k));
          exp_y = exp_y | (W'(beats[k][0]) << (N - 1 - k));
        end
        holding = 1'b1;
        beats.delete();
      end
    end
  endtask

  // Drive one cycle: check outputs mid-cycle, then step the model with the edge.
  task automatic cycle(input logic v, input logic [3:0] c, input logic ordy);
    cat_valid = v;
    cat       = c;
    out_ready = ordy;
    @(negedge clk);
    check("cat_ready", cat_ready, holding ? 0 : 1);
    check("out_valid", out_valid, holding ? 1 : 0);
    check("err", err, exp_err ? 1 : 0);
    if (holding) begin
      check("x", x, exp_x);
      check("y", y, exp_y);
    end
    model_edge(v, c, ordy);
    @(posedge clk);
    #1;
  endtask

  task automatic frame4(input logic [15:0] seq);
    for (int i = 0; i < 4; i++) cycle(1'b1, seq[15 - 4 * i -: 4], 1'b0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cat_valid = 1'b0;
    cat       = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int         idx;
    int         start;
    logic       v;
    logic       ordy;
    logic       acc;
    logic [3:0] c;

    do_reset();
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_cat_ready", cat_ready, 1);

    // Back-to-back frame, then hold it 5 cycles before the handshake.
    frame4(16'hE350);
    check("tp1_out_valid", out_valid, 1);
    check("tp1_x", x, 8'hD8);
    check("tp1_y", y, 8'h06);
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'h0, 1'b0);
    check("tp2_x_stable", x, 8'hD8);
    check("tp2_cat_ready_low", cat_ready, 0);
    cycle(1'b0, 4'h0, 1'b1);
    check("tp2_cat_ready_back", cat_ready, 1);
    check("tp2_x_kept", x, 8'hD8);
    cycle(1'b0, 4'h0, 1'b0);

    // Stray beat in IDLE, then an all-ones frame.
    cycle(1'b1, 4'b0110, 1'b0);
    check("tp3_err", err, 1);
    cycle(1'b0, 4'h0, 1'b0);
    frame4(16'hF777);
    check("tp3_x", x, 8'hFF);
    check("tp3_y", y, 8'h0F);
    cycle(1'b0, 4'h0, 1'b1);

    // Premature start on the third beat.
    cycle(1'b1, 4'b1010, 1'b0);
    cycle(1'b1, 4'b0100, 1'b0);
    cycle(1'b1, 4'b1000, 1'b0);
    check("tp4_err", err, 1);
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b1, 4'b0001, 1'b0);
    check("tp4_x", x, 8'h00);
    check("tp4_y", y, 8'h01);
    cycle(1'b0, 4'h0, 1'b1);

    // Reset mid-frame: partial frame is lost, next frame starts clean.
    cycle(1'b1, 4'hE, 1'b0);
    cycle(1'b1, 4'h3, 1'b0);
    do_reset();
    check("tp5_out_valid", out_valid, 0);
    check("tp5_cat_ready", cat_ready, 1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 1'b1);
    frame4(16'hE350);
    check("tp5_x", x, 8'hD8);
    check("tp5_y", y, 8'h06);
    cycle(1'b0, 4'h0, 1'b1);

    // Randomized well-formed frames with gaps and consumer back-pressure.
    idx   = 0;
    start = words_out;
    for (int cyc = 0; cyc < 20000 && (words_out - start) < 200; cyc++) begin
      v    = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      c    = {(idx == 0) ? 1'b1 : 1'b0, 3'($urandom)};
      acc  = v && !holding;
      cycle(v, c, ordy);
      if (acc) idx = (idx + 1) % N;
    end
    check("random_frames", words_out - start, 200);
    cycle(1'b0, 4'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
